// File: rtl/config_frame_parser_pkg.sv
// Shared definitions for the configuration frame parser: FSM encoding,
// frame geometry and command codes.
package config_frame_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_WRITE  = 2'd0,
    ACT_CLEAR  = 2'd1,
    ACT_REJECT = 2'd2
  } action_t;

  // CMD + four payload bytes + checksum
  localparam int FRAME_LEN   = 6;
  localparam int PAYLOAD_LEN = FRAME_LEN - 2;

  localparam logic [7:0] CMD_OUT_SEL       = 8'd0;
  localparam logic [7:0] CMD_FM_DEMOD_RATE = 8'd12;
  localparam logic [7:0] CMD_MAX_WRITE     = CMD_FM_DEMOD_RATE;
  localparam logic [7:0] CMD_CLEAR_ALL     = 8'd15;

  // Map a command byte to what a checksum-clean frame should do with it.
  // Codes 13, 14 and anything above 15 are undefined and get rejected.
  function automatic action_t cmd_action(input logic [7:0] cmd);
    action_t act;
    if (cmd == CMD_CLEAR_ALL) begin
      act = ACT_CLEAR;
    end else if (cmd <= CMD_MAX_WRITE) begin
      act = ACT_WRITE;
    end else begin
      act = ACT_REJECT;
    end
    return act;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog. Reloads on clear, counts down while enabled and
// flags expiry on the cycle the terminal count is reached, which is
// TIMEOUT_CYCLES-1 enabled cycles after the last clear.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload takes priority; hold at zero once the terminal count is hit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD_VAL;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/config_frame_parser.sv
// UART configuration frame parser. Collects CMD, four payload bytes
// (MSB first) and an XOR checksum, then issues a register write, a
// clear-all, or a frame error one cycle after the checksum byte.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for a CMD byte
// ST_PAYLOAD | collecting payload byte idx_q (0..3)
// ST_CSUM    | waiting for the checksum byte
module config_frame_parser
  import config_frame_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        clear_all,
  output logic        frame_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] buf_q, buf_d;
  logic [7:0]  xor_q, xor_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        clear_all_q, clear_all_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        expired;

  localparam logic [1:0] LAST_IDX = 2'(PAYLOAD_LEN - 1);

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid),
    .enable (state_q != ST_IDLE),
    .expired(expired)
  );

  // Next-state and output decode. A received byte always beats a timeout
  // expiring in the same cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    buf_d       = buf_q;
    xor_d       = xor_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    clear_all_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          xor_d   = rx_data;
          buf_d   = '0;
          idx_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          buf_d = {buf_q[23:0], rx_data};
          xor_d = xor_q ^ rx_data;
          if (idx_q == LAST_IDX) begin
            state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (expired) begin
          state_d     = ST_IDLE;
          buf_d       = '0;
          xor_d       = '0;
          idx_d       = '0;
          frame_err_d = 1'b1;
        end
      end

      ST_CSUM: begin
        if (rx_valid) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          if (rx_data != xor_q) begin
            frame_err_d = 1'b1;
          end else begin
            case (cmd_action(cmd_q))
              ACT_WRITE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cmd_q[3:0];
                wr_data_d = buf_q;
              end
              ACT_CLEAR: clear_all_d = 1'b1;
              default:   frame_err_d = 1'b1;
            endcase
          end
        end else if (expired) begin
          state_d     = ST_IDLE;
          buf_d       = '0;
          xor_d       = '0;
          idx_d       = '0;
          frame_err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Rejected-frame counter, saturating.
  always_comb begin
    err_count_d = err_count_q;
    if (frame_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cmd_q       <= '0;
      buf_q       <= '0;
      xor_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      clear_all_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      buf_q       <= buf_d;
      xor_q       <= xor_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      clear_all_q <= clear_all_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign clear_all = clear_all_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_config_frame_parser.sv
// Scoreboard bench for config_frame_parser: stimulus pushes the expected
// pulse (kind, due cycle, address/data, error count); a negedge monitor
// pops and compares whenever the DUT raises wr_en, clear_all or frame_err.
module tb_config_frame_parser;

  localparam int TO = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_all;
  logic        frame_err;
  logic        busy;
  logic [7:0]  err_count;

  config_frame_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clear_all(clear_all),
    .frame_err(frame_err),
    .busy     (busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_WR = 0, EV_CLR = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [7:0]  errc;
    int          due;
  } ev_t;

  ev_t sbq[$];
  int total = 0;
  int bad   = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [3:0] a, input logic [31:0] d, input int due);
    ev_t e;
    if (k == EV_ERR && exp_err < 255) exp_err++;
    e.kind = k; e.addr = a; e.data = d; e.errc = 8'(exp_err); e.due = due;
    sbq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, output int s);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    s = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] p,
                            input logic [7:0] cs, input ev_kind_t k);
    int s;
    send_byte(cmd, s);
    send_byte(p[31:24], s);
    send_byte(p[23:16], s);
    send_byte(p[15:8], s);
    send_byte(p[7:0], s);
    send_byte(cs, s);
    push_ev(k, cmd[3:0], p, s + 1);
  endtask

  // Monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (wr_en || clear_all || frame_err)) begin
      ev_t e;
      int kind_got;
      check("exclusive", 32'(int'(wr_en) + int'(clear_all) + int'(frame_err)), 32'd1);
      kind_got = wr_en ? 0 : (clear_all ? 1 : 2);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d want none", kind_got, cyc);
      end else begin
        e = sbq.pop_front();
        check("kind", 32'(kind_got), 32'(int'(e.kind)));
        check("latency", 32'(cyc), 32'(e.due));
        if (e.kind == EV_WR) begin
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", wr_data, e.data);
        end
        check("err_count", 32'(err_count), 32'(e.errc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_clear_all", 32'(clear_all), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // Basic write, with busy while mid-frame and output hold afterwards.
    send_byte(8'h02, s);
    send_byte(8'h00, s);
    check("busy_mid", 32'(busy), 32'd1);
    send_byte(8'h00, s);
    send_byte(8'h10, s);
    send_byte(8'h00, s);
    send_byte(8'h12, s);
    push_ev(EV_WR, 4'd2, 32'h0000_1000, s + 1);
    idle(4);
    check("busy_after", 32'(busy), 32'd0);
    check("hold_addr", 32'(wr_addr), 32'd2);
    check("hold_data", wr_data, 32'h0000_1000);

    // Clear-all.
    send_frame(8'h0F, 32'h0000_0000, 8'h0F, EV_CLR);
    idle(3);

    // Reset mid-frame, with a byte offered in the reset cycle.
    send_byte(8'h07, s);
    send_byte(8'h11, s);
    send_byte(8'h22, s);
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h55;
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_errc", 32'(err_count), 32'd0);
    exp_err = 0;
    idle(2);
    send_frame(8'h0C, 32'hDEAD_BEEF, 8'h2E, EV_WR);
    idle(3);

    // Rejections: bad checksum, undefined commands 13 and 0x21.
    send_frame(8'h02, 32'h0000_1000, 8'h13, EV_ERR);
    idle(3);
    check("errc_one", 32'(err_count), 32'd1);
    send_frame(8'h0D, 32'h0000_0000, 8'h0D, EV_ERR);
    send_frame(8'h21, 32'h0000_0000, 8'h21, EV_ERR);
    idle(3);

    // Timeout abort after 05 AA, then a clean frame.
    send_byte(8'h05, s);
    send_byte(8'hAA, s);
    push_ev(EV_ERR, 4'd0, 32'd0, s + 1 + TO);
    idle(TO + 2);
    check("to_busy", 32'(busy), 32'd0);
    send_frame(8'h01, 32'h0000_0003, 8'h02, EV_WR);
    idle(3);

    // Byte arriving exactly on the expiry cycle is accepted.
    send_byte(8'h06, s);
    send_byte(8'h01, s);
    idle(TO - 1);
    send_byte(8'h02, s);
    send_byte(8'h03, s);
    send_byte(8'h04, s);
    send_byte(8'h02, s);
    push_ev(EV_WR, 4'd6, 32'h0102_0304, s + 1);
    idle(3);

    // Back-to-back bad frames saturate err_count; next frame still parses.
    for (int i = 0; i < 260; i++) begin
      send_frame(8'h03, 32'h0000_0001, 8'h00, EV_ERR);
    end
    send_frame(8'h04, 32'h0000_0009, 8'h0D, EV_WR);
    idle(3);
    check("errc_sat", 32'(err_count), 32'd255);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) idle(1);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_frame_parser.md
CONFIG_FRAME_PARSER -- requirements
Module: config_frame_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000, inter-byte timeout in clk cycles (2 ms at 1 MHz).
REQ-002 clk  input  1  single clock for all logic; rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_valid  input  1  one-cycle strobe per received UART byte.
REQ-005 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-006 wr_en  output  1  one-cycle register-write pulse.
REQ-007 wr_addr  output  4  target register index; held until next wr_en.
REQ-008 wr_data  output  32  write value; held until next wr_en.
REQ-009 clear_all  output  1  one-cycle pulse commanding all config registers to zero.
REQ-010 frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-011 busy  output  1  high while a frame is partially received.
REQ-012 err_count  output  8  count of rejected frames, saturating at 255.

Function
REQ-013 Frame SHALL be 6 bytes: CMD, P3, P2, P1, P0 (payload MSB first), CSUM.
REQ-014 CSUM SHALL equal the XOR of CMD and P3..P0.
REQ-015 The FSM SHALL have three states: IDLE, PAYLOAD (2-bit index 0..3), CSUM.
REQ-016 IDLE + rx_valid SHALL latch CMD, clear the running XOR to CMD, and go to PAYLOAD index 0.
REQ-017 PAYLOAD + rx_valid SHALL shift the byte into a 32-bit buffer and XOR it in; after index 3, go to CSUM.
REQ-018 CSUM + rx_valid SHALL return to IDLE and evaluate the frame on that same edge.
REQ-019 Valid frame with CMD 0..12 SHALL drive wr_en=1, wr_addr=CMD[3:0], and wr_data=buffer in the cycle after the CSUM strobe (latency 1).
REQ-020 Valid frame with CMD 15 SHALL drive clear_all=1 in the cycle after the CSUM strobe; wr_en stays 0.
REQ-021 CMD 13, 14 or >15, or a CSUM mismatch, SHALL pulse frame_err and SHALL NOT pulse wr_en or clear_all.
REQ-022 An invalid CMD SHALL still consume all 6 bytes before being rejected.
REQ-023 Byte-width commands SHALL be written with the full 32-bit buffer; truncation is the consumer's responsibility.
REQ-024 The timeout counter SHALL clear on every rx_valid and count while not in IDLE.
REQ-025 If the counter reaches TIMEOUT_CYCLES-1 with no rx_valid, the block SHALL go to IDLE, pulse frame_err, discard the buffer, and SHALL NOT write.
REQ-026 rx_valid in the same cycle as timeout expiry SHALL win: byte accepted, no abort.
REQ-027 rx_valid in the cycle wr_en, clear_all or frame_err is high SHALL be accepted as a new CMD byte.
REQ-028 err_count SHALL increment by 1 per frame_err pulse and hold at 255.
REQ-029 busy SHALL be 1 in PAYLOAD and CSUM and 0 in IDLE.
REQ-030 wr_en, clear_all and frame_err SHALL be mutually exclusive in any cycle.

Reset
REQ-031 rst SHALL force state IDLE and zero the buffer, running XOR, timeout counter and err_count.
REQ-032 rst SHALL set wr_en, clear_all, frame_err, busy, wr_addr and wr_data to 0.
REQ-033 rst mid-frame SHALL discard the partial frame without pulsing frame_err.
REQ-034 rst SHALL take priority over rx_valid in the same cycle.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, FRAME_LEN=6, and the command codes (CMD_OUT_SEL=0 .. CMD_FM_DEMOD_RATE=12, CMD_CLEAR_ALL=15, CMD_MAX_WRITE=12).
REQ-036 The inter-byte timeout SHALL be one sub-module, byte_timeout_timer (inputs clear, enable; output expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-037 Send 02 00 00 10 00, CSUM 12 -> one wr_en pulse, wr_addr=2, wr_data=0x00001000, one cycle after the last strobe.
REQ-038 Send 0F 00 00 00 00, CSUM 0F -> clear_all pulse only, wr_en=0.
REQ-039 Send 02 00 00 10 00, CSUM 13 -> frame_err pulse, no wr_en, err_count=1.
REQ-040 Send 05 AA, then idle 2000 cycles -> frame_err at expiry, busy falls; a following valid frame 01 00 00 00 03 CSUM 02 writes addr 1 data 3.
REQ-041 Assert rst after 3 bytes of a frame -> busy=0, no frame_err, err_count unchanged; the next full valid frame writes correctly.
REQ-042 Send 256+ bad-CSUM frames back-to-back, with rx_valid in each frame_err cycle -> err_count saturates at 255, and each new frame starts correctly.
